rx: RTL and testbench

Parameterised asynchronous UART receiver. It sits directly downstream of the team's `tx` transmitter on the serial line and recovers each frame back into a byte. Frame format: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1). The received byte is presented with a one-cycle strobe and parity/framing status flags.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_sync2.sv | 24 ++
 rtl/rx.sv | 108 ++++++++++
 tb/tb_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the tx/rx pair.
// Parity modes, frame length and bit timing helper.
package uart_pkg;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;
  localparam int DATA_BITS   = 8;

  function automatic int bitCycles(
    input int clkFreq,
    input int baudRate
  );
    return clkFreq / baudRate;
  endfunction

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for an asynchronous input.
// Both flops reset to RST_VAL so the output starts at idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx.sv
// UART receiver: start, 8 data LSB first, parity, stop.
// Presents each byte with a one-cycle strobe and error flags.
module rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD_RATE   = 19200,
  parameter int PARITY_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strb,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CYCLES  = bitCycles(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int TW = $clog2(BIT_CYCLES + 1);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic ODD = (PARITY_MODE == PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE, START, BITS, PAR, STOP, BRK
  } state_t;

  state_t state, stateNext;

  logic                 rxS;
  logic [TW-1:0]        timer;
  logic [CW-1:0]        bitCnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 parBit;
  logic                 hit;
  logic                 lastBit;

  sync2 #(.RST_VAL(1'b1)) uSync (
    .clk(clk),
    .rst(rst),
    .d  (rx_in),
    .q  (rxS)
  );

  always_comb begin
    hit = (state == START)
        ? (timer == TW'(HALF_CYCLES - 1))
        : (timer == TW'(BIT_CYCLES - 1));
    lastBit   = (bitCnt == CW'(DATA_BITS - 1));
    stateNext = state;
    unique case (state)
      IDLE:  if (!rxS) stateNext = START;
      START: if (hit) stateNext = rxS ? IDLE : BITS;
      BITS:  if (hit && lastBit) stateNext = PAR;
      PAR:   if (hit) stateNext = STOP;
      STOP:  if (hit) stateNext = rxS ? IDLE : BRK;
      BRK:   if (rxS) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      bitCnt     <= '0;
      shreg      <= '0;
      parBit     <= 1'b0;
      dout       <= '0;
      data_strb  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_strb <= 1'b0;
      // timer restarts at every sample point
      if (state == IDLE || state == BRK || hit)
        timer <= '0;
      else
        timer <= timer + 1'b1;
      if (state == START && hit)
        bitCnt <= '0;
      if (state == BITS && hit) begin
        shreg  <= {rxS, shreg[DATA_BITS-1:1]};
        bitCnt <= bitCnt + 1'b1;
      end
      if (state == PAR && hit)
        parBit <= rxS;
      if (state == STOP && hit) begin
        dout       <= shreg;
        parity_err <= (^{shreg, parBit}) != ODD;
        frame_err  <= ~rxS;
        data_strb  <= 1'b1;
      end
      if (state == START && hit && !rxS)
        busy <= 1'b1;
      else if (stateNext == IDLE && state != IDLE)
        busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx.sv
// Randomised and directed bench for the UART receiver.
// A line driver mimics tx timing; a model predicts each frame.
module tb_rx;

  localparam int CF  = 6400000;
  localparam int BR  = 100000;
  localparam int BIT = CF / BR;
  localparam int HALF = BIT / 2;
  localparam int PM  = 1;
  localparam int TXP = BIT + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       busyAfter;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] dout;
  logic       data_strb;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad = 0;
  int strbCnt = 0;
  bit busySeen = 0;
  bit havePend = 0;
  rec_t pend;
  rec_t q[$];

  always #5 clk = ~clk;

  rx #(
    .CLK_FREQ   (CF),
    .BAUD_RATE  (BR),
    .PARITY_MODE(PM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .dout      (dout),
    .data_strb (data_strb),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (busy === 1'b1) busySeen = 1;
    if (havePend) begin
      pend.busyAfter = busy;
      q.push_back(pend);
      havePend = 0;
    end
    if (data_strb === 1'b1) begin
      pend.d  = dout;
      pend.pe = parity_err;
      pend.fe = frame_err;
      havePend = 1;
      strbCnt++;
    end
  end

  function automatic logic goodPar(input logic [7:0] d);
    return logic'(($countones(d) + PM) % 2);
  endfunction

  function automatic logic expPe(input logic [7:0] d, input logic pb);
    return logic'((($countones(d) + int'(pb)) % 2) != PM);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sendBits(input logic [10:0] bits,
                          input int n);
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      repeat (TXP) @(negedge clk);
    end
  endtask

  task automatic sendFrame(input logic [7:0] d,
                           input logic pb,
                           input logic sb);
    sendBits({sb, pb, d, 1'b0}, 11);
  endtask

  task automatic getRec(input string tag, output rec_t r);
    int n = 0;
    while (q.size() == 0 && n < 4 * TXP) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s timeout got=none exp=strobe", tag);
      r = '{8'h00, 1'b0, 1'b0, 1'b0};
    end else begin
      r = q.pop_front();
    end
  endtask

  task automatic expectFrame(input string tag,
                             input logic [7:0] d,
                             input logic pe,
                             input logic fe);
    rec_t r;
    getRec(tag, r);
    check({tag, "_dout"}, 32'(r.d), 32'(d));
    check({tag, "_pe"}, 32'(r.pe), 32'(pe));
    check({tag, "_fe"}, 32'(r.fe), 32'(fe));
  endtask

  initial begin
    rec_t r;
    int sc;
    logic [7:0] d;
    logic [7:0] rd[8];
    logic rp[8];
    logic [7:0] keep;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dout", 32'(dout), 0);
    check("rst_strb", 32'(data_strb), 0);
    check("rst_pe", 32'(parity_err), 0);
    check("rst_fe", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (20) @(negedge clk);

    // single clean frame
    sendFrame(8'hA5, goodPar(8'hA5), 1'b1);
    getRec("t1", r);
    check("t1_dout", 32'(r.d), 32'hA5);
    check("t1_pe", 32'(r.pe), 0);
    check("t1_fe", 32'(r.fe), 0);
    check("t1_busyAfter", 32'(r.busyAfter), 0);
    check("t1_hold", 32'(dout), 32'hA5);

    // back-to-back frames
    sendFrame(8'h00, goodPar(8'h00), 1'b1);
    sendFrame(8'hFF, goodPar(8'hFF), 1'b1);
    sendFrame(8'h3C, goodPar(8'h3C), 1'b1);
    expectFrame("t2a", 8'h00, 1'b0, 1'b0);
    expectFrame("t2b", 8'hFF, 1'b0, 1'b0);
    expectFrame("t2c", 8'h3C, 1'b0, 1'b0);

    // wrong parity bit
    sendFrame(8'h5A, 1'b0, 1'b1);
    expectFrame("t3", 8'h5A, 1'b1, 1'b0);

    // random back-to-back frames, random parity correctness
    for (int i = 0; i < 8; i++) begin
      rd[i] = 8'($urandom);
      rp[i] = ($urandom_range(0, 3) == 0)
            ? ~goodPar(rd[i]) : goodPar(rd[i]);
      sendFrame(rd[i], rp[i], 1'b1);
    end
    for (int i = 0; i < 8; i++)
      expectFrame("rnd", rd[i], expPe(rd[i], rp[i]), 1'b0);

    // framing error followed by a held-low break
    repeat (30) @(negedge clk);
    sc = strbCnt;
    sendFrame(8'h81, goodPar(8'h81), 1'b0);
    repeat (3 * BIT) @(negedge clk);
    check("t4_busyLow", 32'(busy), 1);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_busyEnd", 32'(busy), 0);
    repeat (3 * BIT) @(negedge clk);
    check("t4_strbCnt", 32'(strbCnt - sc), 1);
    getRec("t4", r);
    check("t4_dout", 32'(r.d), 32'h81);
    check("t4_pe", 32'(r.pe), 0);
    check("t4_fe", 32'(r.fe), 1);
    check("t4_busyAfter", 32'(r.busyAfter), 1);

    // glitches shorter than half a bit
    keep = dout;
    sc = strbCnt;
    busySeen = 0;
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b0;
      repeat ($urandom_range(1, HALF - 6)) @(negedge clk);
      rx_in = 1'b1;
      repeat (2 * BIT) @(negedge clk);
    end
    check("t5_strb", 32'(strbCnt - sc), 0);
    check("t5_busy", 32'(busySeen), 0);
    check("t5_dout", 32'(dout), 32'(keep));

    // reset in the middle of data bit 4
    d = 8'h77;
    sendBits({2'b11, d, 1'b0}, 5);
    rx_in = d[4];
    repeat (20) @(negedge clk);
    check("t6_busyPre", 32'(busy), 1);
    rx_in = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_dout", 32'(dout), 0);
    check("t6_strb", 32'(data_strb), 0);
    check("t6_pe", 32'(parity_err), 0);
    check("t6_fe", 32'(frame_err), 0);
    check("t6_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("t6_noStrb", 32'(q.size()), 0);
    sendFrame(8'h12, goodPar(8'h12), 1'b1);
    expectFrame("t6_after", 8'h12, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
